// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, control encodings and fetch states
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int CTRL_W      = 6;
    localparam int IF_BIT      = 1;

    localparam logic              RST_ENABLE = 1'b1;
    localparam logic              JUMP       = 1'b1;
    localparam logic              STOP       = 1'b1;
    localparam logic [INST_W-1:0] ZERO_WORD  = '0;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: PC owner and byte-wise instruction assembler
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CTRL_W-1:0]      stall,
    input  logic                   jumpout,
    input  logic [INST_ADDR_W-1:0] jump_addr,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic                   mem_ready,
    input  logic [BYTE_W-1:0]      mem_data,
    output logic                   stallreq_if,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst
);

    if_state_t              state_q, state_d;
    logic [INST_ADDR_W-1:0] pc, pc_d;
    logic [1:0]             cnt, cnt_d;
    logic [23:0]            byte_buf, byte_buf_d;
    logic [INST_W-1:0]      inst_d;

    // Only the IF bit of the stall vector concerns this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[CTRL_W-1:IF_BIT+1], stall[IF_BIT-1:0]};

    // The byte address walks pc..pc+3 as cnt counts accepted bytes; wraps mod 2^32.
    assign mem_addr    = pc + {30'd0, cnt};
    assign stallreq_if = (state_q != IF_HOLD);
    assign if_pc       = pc;

    // Next-state, byte capture and request generation; a jump overrides every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        cnt_d      = cnt;
        byte_buf_d = byte_buf;
        inst_d     = if_inst;
        mem_req    = 1'b0;
        if (jumpout == JUMP) begin
            pc_d       = jump_addr;
            cnt_d      = 2'd0;
            byte_buf_d = 24'd0;
            state_d    = IF_FETCH;
        end else begin
            case (state_q)
                IF_IDLE: state_d = IF_FETCH;
                IF_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        if (cnt == 2'd3) begin
                            inst_d  = {mem_data, byte_buf};
                            cnt_d   = 2'd0;
                            state_d = IF_HOLD;
                        end else begin
                            byte_buf_d[{cnt, 3'b000} +: 8] = mem_data;
                            cnt_d = cnt + 2'd1;
                        end
                    end
                end
                IF_HOLD: begin
                    if (stall[IF_BIT] != STOP) begin
                        pc_d    = pc + 32'd4;
                        state_d = IF_FETCH;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    // State registers; reset aborts any fetch in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q  <= IF_IDLE;
            pc       <= RESET_PC;
            cnt      <= 2'd0;
            byte_buf <= 24'd0;
            if_inst  <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            cnt      <= cnt_d;
            byte_buf <= byte_buf_d;
            if_inst  <= inst_d;
        end
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RISC-V core. Owns the PC and assembles one 32-bit instruction from four byte-wide memory reads, presenting `if_pc`/`if_inst` to the IF/ID pipeline register. Requests a pipeline stall from ctrl while a fetch is in flight, and restarts at the branch target when ID signals a jump.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  reset. Asynchronous, active-high (`RstEnable`).
- `stall`  in  `CtrlWidth`  from ctrl; `stall[IF_BIT] == Stop` freezes the PC.
- `jumpout`  in  1  from id; `Jump` means redirect fetch.
- `jump_addr`  in  `InstAddrBus`  from id; redirect target, valid with `jumpout`.
- `mem_req`  out  1  byte-read request to mem_ctrl.
- `mem_addr`  out  `InstAddrBus`  byte address of the current request.
- `mem_ready`  in  1  `mem_data` holds the requested byte this cycle.
- `mem_data`  in  8  returned byte.
- `stallreq_if`  out  1  to ctrl; high while no complete instruction is available.
- `if_pc`  out  `InstAddrBus`  PC of the instruction in `if_inst`.
- `if_inst`  out  `InstBus`  assembled instruction.

## Operation
- Registers: `pc`, `cnt[1:0]`, `buf[23:0]` (bytes 0–2), `state`.
- States:
  - IDLE: entered on reset.
  - FETCH: requesting bytes.
  - HOLD: instruction complete, waiting on stall.
- Reset (async): `pc=RESET_PC`, `cnt=0`, `buf=0`, `if_inst=ZeroWord`, `state=IDLE`. Outputs during reset: `mem_req=0`, `stallreq_if=1`, `if_pc=RESET_PC`.
- IDLE → FETCH unconditionally on the next edge.
- FETCH:
  - `mem_req=1`, `mem_addr=pc+cnt`.
  - On `mem_ready`, store `mem_data` as byte `cnt`, little-endian, so byte 0 lands in bits [7:0].
  - `cnt` increments on each accepted byte.
  - On the 4th byte (`cnt==3`), `if_inst <= {mem_data, buf}`, `cnt<=0`, go to HOLD.
  - `mem_ready` is ignored outside FETCH.
- HOLD:
  - `mem_req=0`, `stallreq_if=0`.
  - If `stall[IF_BIT]==Stop`, stay in HOLD with `pc` and `if_inst` unchanged.
  - Otherwise `pc<=pc+4` (mod 2^32), go to FETCH.
- `stallreq_if = (state != HOLD)`.
- `if_pc = pc`.
- `if_inst` changes only on 4th-byte capture or reset.
- Jump: `jumpout==Jump` has priority over everything except reset, in any state.
  - Effects: `pc<=jump_addr`, `cnt<=0`, partial `buf` discarded, `state<=FETCH`.
  - `mem_req` is forced 0 in the jump cycle.
  - A `mem_ready` arriving in the jump cycle is dropped, even on the 4th byte.
- Misaligned `jump_addr` is fetched as-is (byte bus); no exception raised.
- PC wrap: `pc=32'hFFFF_FFFC` advances to 0. `mem_addr` wraps the same way mod 2^32.

## Timing
- Minimum fetch latency: 4 cycles in FETCH, with `mem_ready` every cycle, plus 1 cycle in HOLD. Throughput is therefore one instruction per 5 cycles at best.
- `mem_addr` and `mem_req` are combinational from registered state and are stable for the whole cycle.
- mem_ctrl may insert any number of wait cycles: `mem_req` and `mem_addr` hold until `mem_ready`.
- The `if_id` stage samples `if_pc`/`if_inst` on the edge leaving HOLD. That is the only edge where ctrl deasserts the ID stall due to IF.
- A jump in the same cycle as a HOLD → FETCH advance takes the jump target. `pc+4` is never used.
- Reset asserted mid-fetch aborts immediately (async). The bench checks that no stale byte is merged after release.

## Structure
- Shared package (`defs.v`) adds:
  - `IF_BIT`, the stall index.
  - State encodings `IF_IDLE`, `IF_FETCH`, `IF_HOLD` (2 bits).
  - `ByteBus` (7:0).
- It reuses `InstAddrBus`, `InstBus`, `ZeroWord`, `RstEnable`, `Jump`, `Stop`, `CtrlWidth`.
- Single module, no sub-modules. The byte assembler is inline because it shares `cnt` with the address generator.

## Test plan
- **Reset then free-running memory.** Memory holds 0x13,0x05,0x10,0x00 at addresses 0–3, and `mem_ready` is 1 every cycle.
  - `mem_addr` sequence: 0,1,2,3.
  - Then `if_inst=32'h0010_0513`, `if_pc=0`, `stallreq_if=0` for 1 cycle.
  - Then `mem_addr=4`.
- **Wait states.** `mem_ready` is high every 3rd cycle.
  - `mem_addr` holds per byte.
  - HOLD is reached after 12 cycles with the correct word.
- **Downstream stall in HOLD.** `stall[IF_BIT]=Stop` for 5 cycles.
  - `pc`, `if_inst` and `mem_req=0` hold for those 5 cycles.
  - On release, `pc=4` and `mem_addr=4`.
- **Jump mid-fetch.** After bytes 0 and 1 arrive, pulse `jumpout` with `jump_addr=32'h100` and `mem_ready=1`.
  - The byte in the jump cycle is dropped and `mem_req=0` that cycle.
  - Next cycle `mem_addr=0x100`.
  - The resulting instruction is bytes 0x100–0x103 only.
- **Jump coincident with HOLD advance.** `if_pc` becomes 0x200 (the target), not 0x4.
- **Async reset mid-fetch, plus wrap.**
  - Assert `rst` between edges: `mem_req` drops immediately and `if_pc` returns to 0.
  - Separately, jump to 0xFFFF_FFFC: `mem_addr` sequence is FC,FD,FE,FF; the next fetch starts at 0.
